// File: rtl/lampfpu_div_sequencer.sv
// Divide-command sequencer in front of the LAMP FPU divider: queues tagged requests,
// issues them one at a time, and returns in-order tagged results with a hang watchdog.

package lampfpu_div_sequencer_pkg;
  typedef enum logic [1:0] {
    FPU_RNDMODE_NEAREST   = 2'd0,
    FPU_RNDMODE_TRUNCATE  = 2'd1,
    FPU_RNDMODE_PLUS_INF  = 2'd2,
    FPU_RNDMODE_MINUS_INF = 2'd3
  } rndModeFPU_t;
endpackage

module lampfpu_div_sequencer
  import lampfpu_div_sequencer_pkg::*;
#(
  parameter int unsigned     DW          = 16,
  parameter int unsigned     DEPTH       = 2,
  parameter int unsigned     TAG_W       = 3,
  parameter int unsigned     TIMEOUT_CYC = 255,
  parameter logic [DW-1:0]   QNAN_VAL    = 16'h7FC0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [DW-1:0]     req_op1_i,
  input  logic [DW-1:0]     req_op2_i,
  input  rndModeFPU_t       req_rnd_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DW-1:0]     rsp_data_o,
  output logic [TAG_W-1:0]  rsp_tag_o,
  output logic              rsp_err_o,
  output logic              div_do_o,
  output logic [DW-1:0]     div_op1_o,
  output logic [DW-1:0]     div_op2_o,
  output rndModeFPU_t       div_rnd_o,
  output logic              div_padv_o,
  input  logic              div_ready_i,
  input  logic              div_valid_i,
  input  logic [DW-1:0]     div_result_i,
  output logic              busy_o
);

  localparam int unsigned     AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned     CW        = AW + 1;
  localparam int unsigned     WDW       = $clog2(TIMEOUT_CYC);
  localparam logic [WDW-1:0]  WDOG_LAST = WDW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0]   CNT_FULL  = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ABORT} state_t;

  typedef struct packed {
    logic [DW-1:0]    op1;
    logic [DW-1:0]    op2;
    rndModeFPU_t      rnd;
    logic [TAG_W-1:0] tag;
  } entry_t;

  state_t           state_q, state_d;
  entry_t           fifo_q [DEPTH];
  entry_t           fifo_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [TAG_W-1:0] tag_cnt_q, tag_cnt_d, cur_tag_q, cur_tag_d;
  logic [WDW-1:0]   wdog_q, wdog_d;
  logic [DW-1:0]    op1_q, op1_d, op2_q, op2_d;
  rndModeFPU_t      rnd_q, rnd_d;
  logic             rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [DW-1:0]    rsp_data_q, rsp_data_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
  logic             do_q, do_d, busy_q, busy_d;
  logic             push_s, pop_s, padv_s, full_s, empty_s, slot_free_s;

  assign full_s      = (count_q == CNT_FULL);
  assign empty_s     = (count_q == {CW{1'b0}});
  assign push_s      = req_valid_i & ~full_s;
  assign slot_free_s = ~rsp_valid_q | rsp_ready_i;

  // Sequencer FSM: pop into command regs, issue, capture or abort, response slot update
  always_comb begin
    state_d     = state_q;
    pop_s       = 1'b0;
    padv_s      = 1'b0;
    do_d        = 1'b0;
    wdog_d      = wdog_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    rnd_d       = rnd_q;
    cur_tag_d   = cur_tag_q;
    rsp_valid_d = rsp_valid_q & ~rsp_ready_i;
    rsp_data_d  = rsp_data_q;
    rsp_tag_d   = rsp_tag_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        // div_valid_i low means the previous result has been released by padv
        if (!empty_s && div_ready_i && !div_valid_i) begin
          pop_s     = 1'b1;
          op1_d     = fifo_q[rd_ptr_q].op1;
          op2_d     = fifo_q[rd_ptr_q].op2;
          rnd_d     = fifo_q[rd_ptr_q].rnd;
          cur_tag_d = fifo_q[rd_ptr_q].tag;
          do_d      = 1'b1;
          state_d   = S_ISSUE;
        end else begin
          state_d   = S_IDLE;
        end
      end
      S_ISSUE: begin
        wdog_d  = {WDW{1'b0}};
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Saturate so a timeout blocked by a full response slot is not missed
        if (wdog_q != WDOG_LAST) begin
          wdog_d = wdog_q + WDW'(1);
        end else begin
          wdog_d = wdog_q;
        end
        if (div_valid_i && slot_free_s) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = div_result_i;
          rsp_tag_d   = cur_tag_q;
          rsp_err_d   = 1'b0;
          padv_s      = 1'b1;
          state_d     = S_IDLE;
        end else if ((wdog_q == WDOG_LAST) && slot_free_s) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = QNAN_VAL;
          rsp_tag_d   = cur_tag_q;
          rsp_err_d   = 1'b1;
          state_d     = S_ABORT;
        end else begin
          state_d     = S_WAIT;
        end
      end
      S_ABORT: begin
        if (div_valid_i) begin
          padv_s  = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_ABORT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request FIFO pointers, occupancy and tag allocation
  always_comb begin
    fifo_d    = fifo_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    tag_cnt_d = tag_cnt_q;
    if (push_s) begin
      fifo_d[wr_ptr_q] = '{op1: req_op1_i, op2: req_op2_i, rnd: req_rnd_i, tag: tag_cnt_q};
      wr_ptr_d         = wr_ptr_q + AW'(1);
      tag_cnt_d        = tag_cnt_q + TAG_W'(1);
    end else begin
      wr_ptr_d         = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Busy reflects the state the block is entering, so it drops right after the last accept
  always_comb begin
    busy_d = (count_d != {CW{1'b0}}) || (state_d != S_IDLE) || rsp_valid_d;
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      for (int i = 0; i < int'(DEPTH); i++) fifo_q[i] <= '0;
      wr_ptr_q    <= {AW{1'b0}};
      rd_ptr_q    <= {AW{1'b0}};
      count_q     <= {CW{1'b0}};
      tag_cnt_q   <= {TAG_W{1'b0}};
      cur_tag_q   <= {TAG_W{1'b0}};
      wdog_q      <= {WDW{1'b0}};
      op1_q       <= {DW{1'b0}};
      op2_q       <= {DW{1'b0}};
      rnd_q       <= FPU_RNDMODE_NEAREST;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= {DW{1'b0}};
      rsp_tag_q   <= {TAG_W{1'b0}};
      rsp_err_q   <= 1'b0;
      do_q        <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      fifo_q      <= fifo_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      tag_cnt_q   <= tag_cnt_d;
      cur_tag_q   <= cur_tag_d;
      wdog_q      <= wdog_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      rnd_q       <= rnd_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_tag_q   <= rsp_tag_d;
      rsp_err_q   <= rsp_err_d;
      do_q        <= do_d;
      busy_q      <= busy_d;
    end
  end

  // padv must land in the same cycle the result is taken, so it stays combinational
  assign div_padv_o  = padv_s;
  assign req_ready_o = ~full_s;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_tag_o   = rsp_tag_q;
  assign rsp_err_o   = rsp_err_q;
  assign div_do_o    = do_q;
  assign div_op1_o   = op1_q;
  assign div_op2_o   = op2_q;
  assign div_rnd_o   = rnd_q;
  assign busy_o      = busy_q;

endmodule

// File: doc/lampfpu_div_sequencer.md
Name: lampfpu_div_sequencer

Overview:
Command sequencer directly upstream of the FPU divider top.
- Accepts divide requests from the CPU/LSU side over a valid/ready handshake and queues them in a small FIFO.
- Issues them one at a time on the divider's do_div/isReady_o/isResultValid_o/padv_i protocol.
- Returns tagged results over a valid/ready response port, with a watchdog that aborts hung operations.

Parameters:
DW, 16, float width (LAMP_FLOAT_DW)
DEPTH, 2, request FIFO entries (power of 2, >=2)
TAG_W, 3, request tag width
TIMEOUT_CYC, 255, max cycles in WAIT before abort (>=4)
QNAN_VAL, 16'h7FC0, data returned on timeout

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
req_valid_i  in  1  request valid
req_ready_o  out  1  FIFO not full
req_op1_i  in  DW  dividend
req_op2_i  in  DW  divisor
req_rnd_i  in  rndModeFPU_t  rounding mode
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response accept
rsp_data_o  out  DW  quotient
rsp_tag_o  out  TAG_W  tag of the request
rsp_err_o  out  1  1 = timeout abort
div_do_o  out  1  do_div to divider
div_op1_o  out  DW  op1_i to divider
div_op2_o  out  DW  op2_i to divider
div_rnd_o  out  rndModeFPU_t  rndMode_i to divider
div_padv_o  out  1  padv_i to divider
div_ready_i  in  1  divider isReady_o
div_valid_i  in  1  divider isResultValid_o
div_result_i  in  DW  divider result_o
busy_o  out  1  FIFO non-empty, or state!=IDLE, or rsp_valid_o

Behaviour:
Reset (asynchronous, all flops):
- state=IDLE; FIFO empty.
- tag counter=0; wdog=0.
- rsp_valid_o=0; rsp_data_o=0; rsp_tag_o=0; rsp_err_o=0.
- div_do_o=0; div_padv_o=0.
- Command regs (div_op1_o, div_op2_o, div_rnd_o)=0 / FPU_RNDMODE_NEAREST.
- busy_o=0.

Request FIFO:
- Push on req_valid_i & req_ready_o. The entry stores {op1, op2, rnd, tag}; tag = tag counter, which then increments modulo 2^TAG_W.
- req_ready_o = !full, registered-count based. It does not depend on a same-cycle pop (no bypass).
- A push into an empty FIFO is visible at the head the next cycle.

FSM:
- IDLE: if FIFO non-empty & div_ready_i & !div_valid_i → pop head into command regs and tag reg, go ISSUE. Otherwise stay.
- ISSUE: div_do_o=1 for exactly this cycle; wdog=0; go WAIT.
- WAIT: wdog increments each cycle.
  - If div_valid_i & (!rsp_valid_o | rsp_ready_i): load rsp_data_o=div_result_i, rsp_tag_o=tag reg, rsp_err_o=0, rsp_valid_o=1; div_padv_o=1 this cycle; go IDLE.
  - Else if wdog==TIMEOUT_CYC-1 & (!rsp_valid_o | rsp_ready_i): load rsp with QNAN_VAL, tag reg, rsp_err_o=1; go ABORT.
- ABORT: wait for div_valid_i, then div_padv_o=1 for one cycle and discard the result; go IDLE.
- Illegal state → IDLE.

Command and divider interface:
- Command regs are held stable from the pop until the next pop. div_op*/div_rnd_o are driven from them directly.
- div_padv_o is asserted only in WAIT-capture or ABORT-discard cycles. It is never asserted while div_valid_i=0.
- Issue after a completion requires div_valid_i low, which is guaranteed one cycle after padv. Back-to-back throughput is therefore latency+3 cycles per op.

Response:
- rsp_valid_o clears on rsp_ready_i unless reloaded in the same cycle; reload-on-accept is allowed.
- Response data is held stable while valid and not ready.
- While the response slot is full and rsp_ready_i=0, the divider's result is left pending: no padv, and the divider stays DONE.
- Responses are strictly in request order.

Simultaneous events:
- Push and pop in the same cycle: count unchanged.
- Push when full is ignored, since req_ready_o=0.
- Reset mid-WAIT clears the sequencer only. The divider shares rst, so both return to IDLE together.

Test Plan:
- Single request 0x3F80 / 0x4000, rnd NEAREST → div_do_o one-cycle pulse two cycles after push; rsp 0x3F00, tag 0, err 0. Exactly one div_padv_o pulse.
- Three back-to-back pushes, DEPTH=2, 0x4040/0x3F80, 0x4100/0x4000, 0x3F80/0x4040 → req_ready_o low after second push until first pop. Responses 0x4040, 0x4080, 0x3EAB with tags 0, 1, 2 in order.
- rsp_ready_i held 0 for 20 cycles with two queued ops → first response held stable. No div_padv_o until accept; second do_div only after first padv and div_valid_i low.
- Stub divider never raising div_valid_i, TIMEOUT_CYC=8 → rsp 0x7FC0, err 1, 8 cycles after ISSUE. FSM in ABORT; late div_valid_i gets one padv and no response.
- Assert rst asynchronously mid-WAIT with two queued requests → all outputs at reset values immediately, FIFO empty, tag 0 on next request.
- Ten requests with TAG_W=3 → tags 0..7, 0, 1; busy_o falls the cycle after last response accepted.
